// File: rtl/axis_ins_pkg.sv
// rtl/axis_ins_pkg.sv - shared types and helpers for the header inserter
// Contents: FSM state enum, header FIFO entry type, keep popcount and
// MSB-aligned keep mask helpers. Widths are sized for the widest supported
// stream (512 bits / 64 bytes); users take the slice they need.
package axis_ins_pkg;

    localparam int HDR_DATA_MAX_WD = 512;
    localparam int HDR_CNT_MAX_WD  = 7;
    localparam int KEEP_MAX_WD     = 64;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [HDR_DATA_MAX_WD-1:0] data;
        logic [HDR_CNT_MAX_WD-1:0]  cnt;
    } hdr_entry_t;

    function automatic logic [HDR_CNT_MAX_WD-1:0] keep_popcount(input logic [KEEP_MAX_WD-1:0] keep);
        logic [HDR_CNT_MAX_WD-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX_WD; i++) begin
            n = n + {{(HDR_CNT_MAX_WD-1){1'b0}}, keep[i]};
        end
        return n;
    endfunction

    // Ones in bits [nbytes-1 : nbytes-cnt], i.e. the top cnt lanes of an
    // nbytes-wide keep vector. cnt must not exceed nbytes.
    function automatic logic [KEEP_MAX_WD-1:0] keep_mask(input logic [HDR_CNT_MAX_WD-1:0] cnt,
                                                          input logic [HDR_CNT_MAX_WD-1:0] nbytes);
        logic [KEEP_MAX_WD-1:0] ones;
        ones = (64'd1 << cnt) - 64'd1;
        return ones << (nbytes - cnt);
    endfunction

endpackage

// File: rtl/axis_hdr_fifo.sv
// rtl/axis_hdr_fifo.sv - synchronous header FIFO
// Ports: clk, rst (async, active-high); push/push_entry write side;
// pop/head read side (head is valid whenever empty=0); full, empty flags.
// Push while full and pop while empty are ignored.
module axis_hdr_fifo
    import axis_ins_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  hdr_entry_t push_entry,
    input  logic       pop,
    output hdr_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    hdr_entry_t       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axis_hdr_insert_pipe.sv
// rtl/axis_hdr_insert_pipe.sv - stream header inserter with byte realignment
// Ports: clk, rst (async, active-high);
//   payload in : valid_in, data_in, keep_in, last_in, ready_in
//   header in  : valid_insert, data_insert, byte_insert_cnt, ready_insert
//   stream out : valid_out, data_out, keep_out, last_out (registered), ready_out
//   stats      : stat_pkt_cnt, stat_byte_cnt (only with AXIS_INS_STATS_EN)
// Byte N-1 (MSB) is first on the wire; keep vectors are MSB-aligned.
module axis_hdr_insert_pipe
    import axis_ins_pkg::*;
#(
    parameter  int DATA_WD      = 32,
    parameter  int HDR_DEPTH    = 2,
    localparam int DATA_BYTE_WD = DATA_WD / 8,
    localparam int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [CNT_WD-1:0]       byte_insert_cnt,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
`ifdef AXIS_INS_STATS_EN
    ,
    output logic [31:0]             stat_pkt_cnt,
    output logic [31:0]             stat_byte_cnt
`endif
);

    localparam int                N     = DATA_BYTE_WD;
    localparam logic [CNT_WD-1:0] N_CNT = CNT_WD'(N);

    function automatic logic [N-1:0] keep_top(input logic [CNT_WD:0] c);
        return N'(keep_mask(HDR_CNT_MAX_WD'(c), HDR_CNT_MAX_WD'(N)));
    endfunction

    state_t              state;
    logic [DATA_WD-1:0]  carry;      // pending bytes, MSB-aligned, low lanes zero
    logic [CNT_WD-1:0]   shift;      // byte offset of payload; 0 = pass-through
    logic [CNT_WD-1:0]   flush_cnt;

    hdr_entry_t          push_entry;
    hdr_entry_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [CNT_WD-1:0]   s_clamped;
    logic [DATA_WD-1:0]  hdr_data;
    logic [CNT_WD-1:0]   hdr_cnt;
    logic [DATA_WD-1:0]  hdr_bits;
    logic [N-1:0]        hdr_keep;
    logic                unused_head_bits;

    logic                out_free;
    logic                accept;
    logic [CNT_WD-1:0]   v_cnt;
    logic [CNT_WD:0]     total;
    logic [DATA_WD-1:0]  beat_data;
    logic [DATA_WD-1:0]  next_carry;

    always_comb begin
        s_clamped = byte_insert_cnt;
        if (byte_insert_cnt == '0 || byte_insert_cnt > N_CNT) begin
            s_clamped = N_CNT;
        end
        push_entry                    = '0;
        push_entry.data[DATA_WD-1:0]  = data_insert;
        push_entry.cnt[CNT_WD-1:0]    = s_clamped;
    end

    axis_hdr_fifo #(.DEPTH(HDR_DEPTH)) u_hdr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (valid_insert),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign ready_insert     = ~fifo_full;
    assign fifo_pop         = (state == IDLE) && !fifo_empty;
    assign hdr_data         = head.data[DATA_WD-1:0];
    assign hdr_cnt          = head.cnt[CNT_WD-1:0];
    assign unused_head_bits = ^head;

    // Header lanes below the S valid bytes are garbage; zero them so the
    // carry can simply be OR-ed with the shifted payload.
    always_comb begin
        hdr_keep = keep_top({1'b0, hdr_cnt});
        hdr_bits = '0;
        for (int b = 0; b < N; b++) begin
            hdr_bits[b*8 +: 8] = {8{hdr_keep[b]}};
        end
    end

    assign out_free = ~valid_out | ready_out;
    assign ready_in = (state == STREAM) && out_free;
    assign accept   = valid_in && ready_in;

    // Shifting by a full word (shift = 0 on the carry side) yields zero,
    // which is exactly the pass-through behaviour.
    assign v_cnt      = CNT_WD'(keep_popcount(KEEP_MAX_WD'(keep_in)));
    assign total      = {1'b0, shift} + {1'b0, v_cnt};
    assign beat_data  = carry | (data_in >> {shift, 3'b000});
    assign next_carry = data_in << {N_CNT - shift, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            carry     <= '0;
            shift     <= '0;
            flush_cnt <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (out_free) begin
                valid_out <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        carry <= hdr_data & hdr_bits;
                        shift <= hdr_cnt;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (shift != N_CNT) begin
                        state <= STREAM;
                    end else if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= carry;
                        keep_out  <= '1;
                        last_out  <= 1'b0;
                        carry     <= '0;
                        shift     <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        valid_out <= 1'b1;
                        data_out  <= beat_data;
                        carry     <= next_carry;
                        if (!last_in) begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                        end else if (total <= {1'b0, N_CNT}) begin
                            keep_out <= keep_top(total);
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            keep_out  <= '1;
                            last_out  <= 1'b0;
                            flush_cnt <= CNT_WD'(total - {1'b0, N_CNT});
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= carry;
                        keep_out  <= keep_top({1'b0, flush_cnt});
                        last_out  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An empty last beat has no defined realignment.
    a_last_not_empty: assert property (@(posedge clk) disable iff (rst)
        (accept && last_in) |-> (keep_in != '0));

`ifdef AXIS_INS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else if (valid_out && ready_out) begin
            stat_byte_cnt <= stat_byte_cnt + 32'(keep_popcount(KEEP_MAX_WD'(keep_out)));
            if (last_out) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_hdr_insert_pipe.sv
// tb/tb_axis_hdr_insert_pipe.sv - scoreboard bench for axis_hdr_insert_pipe (N=4)
module tb_axis_hdr_insert_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [2:0]  byte_insert_cnt = '0;
    logic        ready_insert;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
`ifdef AXIS_INS_STATS_EN
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_byte_cnt;
`endif

    axis_hdr_insert_pipe #(.DATA_WD(32), .HDR_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out)
`ifdef AXIS_INS_STATS_EN
        ,
        .stat_pkt_cnt    (stat_pkt_cnt),
        .stat_byte_cnt   (stat_byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  rand_ready = 1'b0;
    logic  ready_val = 1'b1;

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back('{d: d, k: k, l: l});
    endtask

    task automatic send_hdr(input logic [31:0] d, input logic [2:0] s);
        int n = 0;
        @(negedge clk);
        valid_insert = 1'b1; data_insert = d; byte_insert_cnt = s;
        while (!ready_insert) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL hdr_timeout: ready_insert stuck at 0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1 valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        @(negedge clk);
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        while (!ready_in) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL beat_timeout: ready_in stuck at 0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1 valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #2 ready_out = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    endtask

    task automatic monitor();
        logic        held = 1'b0;
        logic [31:0] hd;
        logic [3:0]  hk;
        logic        hl;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                vectors++;
                if (!valid_out || data_out !== hd || keep_out !== hk || last_out !== hl) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h k=%b l=%b, expected v=1 d=%h k=%b l=%b",
                             valid_out, data_out, keep_out, last_out, hd, hk, hl);
                end
            end
            held = valid_out && !ready_out;
            hd = data_out; hk = keep_out; hl = last_out;
            if (valid_out && ready_out) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: got d=%h k=%b l=%b, expected no beat", data_out, keep_out, last_out);
                end else begin
                    e = exp_q.pop_front();
                    if ((data_out & bmask(e.k)) !== (e.d & bmask(e.k)) || keep_out !== e.k || last_out !== e.l) begin
                        miscompares++;
                        $display("FAIL out_beat: got d=%h k=%b l=%b, expected d=%h k=%b l=%b",
                                 data_out, keep_out, last_out, e.d, e.k, e.l);
                    end
                end
            end
        end
    endtask

    task automatic watchdog();
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    endtask

    initial begin
        fork
            drive_ready();
            monitor();
            watchdog();
        join_none

        repeat (3) @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_last_out", 32'(last_out), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_keep_out", 32'(keep_out), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd0);
        check("rst_ready_insert", 32'(ready_insert), 32'd1);
`ifdef AXIS_INS_STATS_EN
        check("rst_stat_pkt", stat_pkt_cnt, 32'd0);
        check("rst_stat_byte", stat_byte_cnt, 32'd0);
`endif
        rst = 1'b0;

        // S=2, last beat fits
        expect_beat(32'hAABB1122, 4'b1111, 1'b0);
        expect_beat(32'h33445566, 4'b1111, 1'b1);
        send_hdr(32'hAABBCCDD, 3'd2);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        drain();

        // S=2, last beat overflows into a flush beat
        expect_beat(32'hAABB1122, 4'b1111, 1'b0);
        expect_beat(32'h33445566, 4'b1111, 1'b0);
        expect_beat(32'h77000000, 4'b1000, 1'b1);
        send_hdr(32'hAABBCCDD, 3'd2);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1110, 1'b1);
        drain();

        // S=N: header as its own beat, then pass-through
        expect_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        expect_beat(32'h11000000, 4'b1000, 1'b1);
        send_hdr(32'hAABBCCDD, 3'd4);
        send_beat(32'h11223344, 4'b1000, 1'b1);
        drain();

        // Queued headers: fill FIFO while a packet waits, then apply in order
        expect_beat(32'hAABB1122, 4'b1111, 1'b0);
        expect_beat(32'h33440000, 4'b1100, 1'b1);
        expect_beat(32'h01102030, 4'b1111, 1'b0);
        expect_beat(32'h40500000, 4'b1100, 1'b1);
        expect_beat(32'hA0B0C0DE, 4'b1111, 1'b0);
        expect_beat(32'hADBEEF12, 4'b1111, 1'b0);
        expect_beat(32'h34560000, 4'b1100, 1'b1);
        send_hdr(32'hAABBCCDD, 3'd2);
        repeat (4) @(negedge clk);
        send_hdr(32'h01020304, 3'd1);
        send_hdr(32'hA0B0C0D0, 3'd3);
        @(negedge clk);
        check("fifo_full_ready_insert", 32'(ready_insert), 32'd0);
        send_beat(32'h11223344, 4'b1111, 1'b1);
        send_beat(32'h10203040, 4'b1111, 1'b0);
        send_beat(32'h50607080, 4'b1000, 1'b1);
        send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
        send_beat(32'h12345678, 4'b1110, 1'b1);
        drain();

        // 5-beat packet under random backpressure
        expect_beat(32'hCA001122, 4'b1111, 1'b0);
        expect_beat(32'h33445566, 4'b1111, 1'b0);
        expect_beat(32'h778899AA, 4'b1111, 1'b0);
        expect_beat(32'hBBCCDDEE, 4'b1111, 1'b0);
        expect_beat(32'hFF0F1E2D, 4'b1111, 1'b0);
        expect_beat(32'h3C000000, 4'b1000, 1'b1);
        rand_ready = 1'b1;
        send_hdr(32'hCAFEBABE, 3'd1);
        send_beat(32'h00112233, 4'b1111, 1'b0);
        send_beat(32'h44556677, 4'b1111, 1'b0);
        send_beat(32'h8899AABB, 4'b1111, 1'b0);
        send_beat(32'hCCDDEEFF, 4'b1111, 1'b0);
        send_beat(32'h0F1E2D3C, 4'b1111, 1'b1);
        drain();
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-packet with a stalled output and a full header FIFO
        ready_val = 1'b0;
        repeat (2) @(negedge clk);
        send_hdr(32'hAABBCCDD, 3'd2);
        repeat (3) @(negedge clk);
        send_hdr(32'h55555555, 3'd3);
        send_hdr(32'h66666666, 3'd1);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        @(negedge clk);
        check("pre_rst_valid_out", 32'(valid_out), 32'd1);
        check("pre_rst_ready_insert", 32'(ready_insert), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid_out", 32'(valid_out), 32'd0);
        check("async_rst_ready_insert", 32'(ready_insert), 32'd1);
        check("async_rst_ready_in", 32'(ready_in), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        ready_val = 1'b1;
`ifdef AXIS_INS_STATS_EN
        check("post_rst_stat_pkt", stat_pkt_cnt, 32'd0);
        check("post_rst_stat_byte", stat_byte_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        expect_beat(32'h12349ABC, 4'b1111, 1'b0);
        expect_beat(32'hDEF00000, 4'b1100, 1'b1);
        send_hdr(32'h12345678, 3'd2);
        send_beat(32'h9ABCDEF0, 4'b1111, 1'b1);
        drain();
`ifdef AXIS_INS_STATS_EN
        check("stat_pkt_cnt", stat_pkt_cnt, 32'd1);
        check("stat_byte_cnt", stat_byte_cnt, 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
